// File: rtl/sram_mem_controller.sv
// MEM-stage bridge from 32-bit loads/stores to a 16-bit asynchronous SRAM.
// Each word is moved as two half-word transfers, stalling the pipeline via ready.
module sram_mem_controller #(
    parameter int unsigned ACCESS_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR     = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    input  logic [15:0] sram_dq_in,
    output logic        sram_dq_oe,
    output logic        sram_we_n,
    output logic        sram_oe_n
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LO   = 2'd1;
    localparam logic [1:0] HI   = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

    logic [1:0]  state_reg;
    logic [3:0]  cnt_reg;
    logic        op_write_reg;
    logic [16:0] index_reg;
    logic [31:0] wdata_reg;
    logic [31:0] read_data_reg;
    logic [31:0] offset;
    logic        last_cycle;
    logic        unused_offset_bits;

    // Byte offset from the SRAM window; wraps freely, low two bits discarded.
    assign offset             = address - BASE_ADDR;
    assign unused_offset_bits = ^{offset[31:19], offset[1:0]};
    assign last_cycle         = (cnt_reg == LAST_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= 4'd0;
            op_write_reg  <= 1'b0;
            index_reg     <= 17'd0;
            wdata_reg     <= 32'd0;
            read_data_reg <= 32'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (wr_en || rd_en) begin
                        state_reg    <= LO;
                        cnt_reg      <= 4'd0;
                        op_write_reg <= wr_en;
                        index_reg    <= offset[18:2];
                        wdata_reg    <= write_data;
                    end
                end
                LO: begin
                    if (last_cycle) begin
                        state_reg <= HI;
                        cnt_reg   <= 4'd0;
                        if (!op_write_reg) read_data_reg[15:0] <= sram_dq_in;
                    end else begin
                        cnt_reg <= cnt_reg + 4'd1;
                    end
                end
                HI: begin
                    if (last_cycle) begin
                        state_reg <= DONE;
                        cnt_reg   <= 4'd0;
                        if (!op_write_reg) read_data_reg[31:16] <= sram_dq_in;
                    end else begin
                        cnt_reg <= cnt_reg + 4'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Pin decode depends only on registered state, never on the live request.
    always_comb begin
        sram_addr   = 18'd0;
        sram_dq_out = 16'd0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        sram_oe_n   = 1'b1;
        if (state_reg == LO || state_reg == HI) begin
            sram_addr = {index_reg, (state_reg == HI)};
            if (op_write_reg) begin
                sram_dq_oe  = 1'b1;
                sram_we_n   = 1'b0;
                sram_dq_out = (state_reg == HI) ? wdata_reg[31:16] : wdata_reg[15:0];
            end else begin
                sram_oe_n = 1'b0;
            end
        end
    end

    // Combinational so the freeze lands in the same cycle as the request.
    assign ready     = ~(wr_en | rd_en) | (state_reg == DONE);
    assign read_data = read_data_reg;

endmodule

// File: tb/tb_sram_mem_controller.sv
// Scoreboard bench: stimulus queues expected SRAM cycles and load results,
// an independent monitor pops and compares them as the controller presents them.
module tb_sram_mem_controller;

    localparam int          A    = 2;
    localparam logic [31:0] BASE = 32'd1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en;
    logic [31:0] address, write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_we_n, sram_oe_n;
    logic        clear_mem;

    int compared   = 0;
    int mismatched = 0;

    sram_mem_controller #(.ACCESS_CYCLES(A), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .address(address), .write_data(write_data), .read_data(read_data),
        .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
        .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe),
        .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
    );

    always #5 clk = ~clk;

    // Board SRAM: half-word array, asynchronous read, write while strobe is low.
    logic [15:0] sram_mem [0:262143];
    assign sram_dq_in = sram_mem[sram_addr];
    always @(posedge clk) begin
        if (clear_mem) begin
            for (int i = 0; i < 262144; i++) sram_mem[i] <= 16'h0;
        end else if (!sram_we_n && sram_dq_oe) begin
            sram_mem[sram_addr] <= sram_dq_out;
        end
    end

    // Reference: word-addressed memory plus the last completed load value.
    logic [31:0] ref_mem [int];
    logic [31:0] last_read;

    typedef struct packed {
        logic [17:0] addr;
        logic        wr;
        logic [15:0] dq;
    } pin_t;

    pin_t        pin_q[$];
    logic [31:0] done_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_rd(input int idx);
        return ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
    endfunction

    // Caller is positioned just after a rising edge; returns just after the edge ending DONE.
    task automatic issue(input logic w, input logic r, input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] off;
        logic [16:0] idx;
        logic        hi;
        int          lowc;
        off = addr - BASE;
        idx = off[18:2];
        for (int k = 0; k < 2 * A; k++) begin
            hi = (k >= A);
            pin_q.push_back('{addr: {idx, hi}, wr: w, dq: hi ? wd[31:16] : wd[15:0]});
        end
        if (w) ref_mem[int'(idx)] = wd;
        else   last_read = ref_rd(int'(idx));
        done_q.push_back(last_read);
        wr_en = w; rd_en = r; address = addr; write_data = wd;
        lowc = 0;
        forever begin
            @(negedge clk);
            if (ready || lowc > 40) break;
            lowc++;
        end
        chk("freeze_cycles", 64'(lowc), 64'(2 * A + 1));
        @(posedge clk); #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; rd_en = 1'b0;
        @(negedge clk);
        chk("idle_pins", {61'd0, ready, sram_we_n, sram_oe_n}, 64'h7);
        @(posedge clk); #1;
    endtask

    // Monitor: consumes expectations whenever the SRAM is strobed or an access finishes.
    initial begin
        pin_t e;
        logic [31:0] er;
        forever begin
            @(negedge clk);
            if (!rst && (!sram_we_n || !sram_oe_n)) begin
                if (pin_q.size() == 0) begin
                    chk("unexpected_sram_cycle", {46'd0, sram_addr}, 64'h0 - 1);
                end else begin
                    e = pin_q.pop_front();
                    chk("sram_pins",
                        {27'd0, sram_addr, sram_we_n, sram_oe_n, sram_dq_oe, e.wr ? sram_dq_out : 16'h0},
                        {27'd0, e.addr, ~e.wr, e.wr, e.wr, e.wr ? e.dq : 16'h0});
                end
            end
            if (!rst && (wr_en || rd_en) && ready) begin
                chk("pending_sram_cycles", 64'(pin_q.size()), 64'd0);
                if (done_q.size() == 0) begin
                    chk("unexpected_done", {32'd0, read_data}, 64'h0 - 1);
                end else begin
                    er = done_q.pop_front();
                    chk("read_data", {32'd0, read_data}, {32'd0, er});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a, d;
        logic        w, r;
        int          idx;
        rst = 1'b1; clear_mem = 1'b1; last_read = 32'h0;
        wr_en = 1'b0; rd_en = 1'b0; address = 32'h0; write_data = 32'h0;
        @(posedge clk); @(negedge clk);
        chk("reset_outputs",
            {read_data, sram_addr, sram_dq_out[13:0]},
            64'h0);
        chk("reset_strobes", {60'd0, ready, sram_we_n, sram_oe_n, sram_dq_oe}, 64'he);
        wr_en = 1'b1; #1;
        chk("reset_ready_req", {63'd0, ready}, 64'd0);
        wr_en = 1'b0;
        @(posedge clk); #1;
        clear_mem = 1'b0; rst = 1'b0;
        @(posedge clk); #1;

        // Directed accesses: basic write/read, address decode, write+read priority, wrap.
        issue(1, 0, 32'd1024, 32'hDEADBEEF); idle();
        issue(0, 1, 32'd1024, 32'h0);        idle();
        issue(1, 0, 32'd1036, 32'h12345678); idle();
        issue(0, 1, 32'd1036, 32'h0);
        issue(0, 1, 32'd1037, 32'h0);        idle();
        issue(1, 1, 32'd1040, 32'hCAFEF00D); idle();
        issue(1, 0, BASE - 32'd4, 32'hA5A55A5A);
        issue(0, 1, BASE - 32'd2, 32'h0);    idle();

        // Reset in the high-half phase of a write must abandon it and clear read_data.
        pin_q.push_back('{addr: 18'd200, wr: 1'b1, dq: 16'h1111});
        pin_q.push_back('{addr: 18'd200, wr: 1'b1, dq: 16'h1111});
        wr_en = 1'b1; address = BASE + 32'd400; write_data = 32'h22221111;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("abort_pins", {29'd0, sram_addr, sram_we_n, sram_oe_n, sram_dq_oe}, {29'd0, 18'd0, 3'b110});
        chk("abort_read_data", {32'd0, read_data}, 64'd0);
        pin_q.delete(); done_q.delete();
        wr_en = 1'b0; last_read = 32'h0;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        issue(0, 1, 32'd1036, 32'h0); idle();

        // Random mix of loads/stores, some back-to-back, within a small window.
        for (int t = 0; t < 60; t++) begin
            idx = int'($urandom_range(0, 31));
            a = BASE + 32'(idx * 4) + 32'($urandom_range(0, 3));
            d = $urandom;
            w = ($urandom_range(0, 1) == 1);
            r = !w || ($urandom_range(0, 3) == 0);
            issue(w, r, a, d);
            if ($urandom_range(0, 2) == 0) idle();
        end
        idle();
        chk("final_queues", 64'(pin_q.size() + done_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
